// File: rtl/metronome_beat_scheduler_if.sv
// metronome_beat_scheduler_if: tempo/bar controls in, arm position, beat and click gate out
interface metronome_beat_scheduler_if;
  logic       run;
  logic [2:0] speed;
  logic [2:0] beats_per_bar;
  logic [2:0] arm_pos;
  logic       arm_dir;
  logic       beat_tick;
  logic       beat_accent;
  logic [2:0] beat_idx;
  logic       click;
  logic       click_accent;
  modport master (
    output run, speed, beats_per_bar,
    input  arm_pos, arm_dir, beat_tick, beat_accent, beat_idx, click, click_accent
  );
  modport slave (
    input  run, speed, beats_per_bar,
    output arm_pos, arm_dir, beat_tick, beat_accent, beat_idx, click, click_accent
  );
endinterface

// File: rtl/metronome_beat_scheduler.sv
// metronome_beat_scheduler: sweeps the arm 0..4, fires beats at end stops, tracks bar position, gates clicks
module metronome_beat_scheduler #(
  parameter int STEP1    = 4687500,
  parameter int STEP2    = 4166667,
  parameter int STEP3    = 3750000,
  parameter int STEP4    = 3409091,
  parameter int TICK_LEN = 2500000
) (
  input  logic clk,
  input  logic rst,
  metronome_beat_scheduler_if.slave bus_io
);
  localparam int GW = $clog2(TICK_LEN + 1);
  typedef enum logic [1:0] {IDLE, SWEEP, PAUSE} state_t;
  state_t        state_q, state_d;
  logic [22:0]   cnt_q, cnt_d, lim;
  logic [2:0]    pos_q, pos_d, idx_q, idx_d, pos_n, bpb;
  logic [3:0]    idx_inc;
  logic [GW-1:0] gate_q, gate_d;
  logic          dir_q, dir_d, tick_q, tick_d, acc_q, acc_d, first_q, first_d;
  logic          click_q, click_d, cacc_q, cacc_d;
  logic          valid, step, beat;
  assign valid   = bus_io.speed inside {3'd1, 3'd2, 3'd3, 3'd4};
  assign lim     = bus_io.speed == 3'd1 ? 23'(STEP1 - 1) :
                   bus_io.speed == 3'd2 ? 23'(STEP2 - 1) :
                   bus_io.speed == 3'd3 ? 23'(STEP3 - 1) : 23'(STEP4 - 1);
  // >= rather than == so a switch to a shorter period steps at once
  assign step    = state_q == SWEEP && bus_io.run && valid && cnt_q >= lim;
  assign pos_n   = dir_q ? pos_q + 3'd1 : pos_q - 3'd1;
  assign beat    = step && (pos_n == 3'd0 || pos_n == 3'd4);
  assign bpb     = bus_io.beats_per_bar == 3'd0 ? 3'd4 : bus_io.beats_per_bar;
  assign idx_inc = {1'b0, idx_q} + 4'd1;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    first_d = first_q;
    idx_d   = idx_q;
    tick_d  = beat;
    acc_d   = 1'b0;
    case (state_q)
      IDLE:    state_d = bus_io.run ? (valid ? SWEEP : PAUSE) : IDLE;
      SWEEP: begin
        state_d = !bus_io.run ? IDLE : !valid ? PAUSE : SWEEP;
        cnt_d   = step ? 23'd0 : (bus_io.run && valid) ? cnt_q + 23'd1 : cnt_q;
        pos_d   = step ? pos_n : pos_q;
        dir_d   = beat ? !dir_q : dir_q;
      end
      PAUSE:   state_d = !bus_io.run ? IDLE : valid ? SWEEP : PAUSE;
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) begin
      cnt_d   = 23'd0;
      pos_d   = 3'd2;
      dir_d   = 1'b1;
      first_d = 1'b1;
    end
    if (beat) begin
      first_d = 1'b0;
      idx_d   = (first_q || idx_inc >= {1'b0, bpb}) ? 3'd0 : idx_inc[2:0];
      acc_d   = idx_d == 3'd0;
    end
    gate_d  = beat ? GW'(TICK_LEN) : gate_q != '0 ? gate_q - GW'(1) : gate_q;
    click_d = beat || gate_q > GW'(1);
    cacc_d  = beat ? acc_d : click_d && cacc_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pos_q   <= 3'd2;
      dir_q   <= 1'b1;
      tick_q  <= 1'b0;
      acc_q   <= 1'b0;
      idx_q   <= '0;
      first_q <= 1'b1;
      gate_q  <= '0;
      click_q <= 1'b0;
      cacc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      gate_q  <= gate_d;
      click_q <= click_d;
      cacc_q  <= cacc_d;
    end
  end
  assign bus_io.arm_pos      = pos_q;
  assign bus_io.arm_dir      = dir_q;
  assign bus_io.beat_tick    = tick_q;
  assign bus_io.beat_accent  = acc_q;
  assign bus_io.beat_idx     = idx_q;
  assign bus_io.click        = click_q;
  assign bus_io.click_accent = cacc_q;
endmodule

// File: tb/tb_metronome_beat_scheduler.sv
// tb_metronome_beat_scheduler: directed scoreboard bench for two parameterisations of the scheduler
module tb_metronome_beat_scheduler;
  typedef struct packed {
    logic [2:0] pos;
    logic       dir, tick, acc;
    logic [2:0] idx;
    logic       click, cacc;
  } vec_t;
  typedef struct {
    string tag;
    bit    b;
    vec_t  v;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  metronome_beat_scheduler_if ia ();
  metronome_beat_scheduler_if ib ();
  metronome_beat_scheduler #(.STEP1(4), .STEP2(8), .STEP3(3), .STEP4(2), .TICK_LEN(3))
    dut_a (.clk(clk), .rst(rst), .bus_io(ia));
  metronome_beat_scheduler #(.STEP1(1), .STEP2(2), .STEP3(3), .STEP4(4), .TICK_LEN(6))
    dut_b (.clk(clk), .rst(rst), .bus_io(ib));
  vec_t oa, ob;
  assign oa = {ia.arm_pos, ia.arm_dir, ia.beat_tick, ia.beat_accent, ia.beat_idx, ia.click, ia.click_accent};
  assign ob = {ib.arm_pos, ib.arm_dir, ib.beat_tick, ib.beat_accent, ib.beat_idx, ib.click, ib.click_accent};
  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  function automatic vec_t mk(int pos, int dir, int tick, int acc, int idx, int click, int cacc);
    vec_t v;
    v.pos = 3'(pos);
    v.dir = 1'(dir);
    v.tick = 1'(tick);
    v.acc = 1'(acc);
    v.idx = 3'(idx);
    v.click = 1'(click);
    v.cacc = 1'(cacc);
    return v;
  endfunction
  // k = edges since SWEEP entry, p = step period, tl = gate length, running at constant speed from IDLE
  function automatic vec_t model(int k, int p, int tl, int bpb);
    int seq[8] = '{2, 3, 4, 3, 2, 1, 0, 1};
    int dr[8]  = '{1, 1, 0, 0, 0, 0, 1, 1};
    int s = k / p;
    int eff = bpb == 0 ? 4 : bpb;
    int bl = s >= 2 ? (s - 2) / 4 : -1;
    int kl = p * (2 + 4 * bl);
    int idx = bl >= 0 ? bl % eff : 0;
    int tick = (bl >= 0 && k == kl) ? 1 : 0;
    int cl = (bl >= 0 && k - kl < tl) ? 1 : 0;
    return mk(seq[s % 8], dr[s % 8], tick, (tick == 1 && idx == 0) ? 1 : 0, idx, cl,
              (cl == 1 && idx == 0) ? 1 : 0);
  endfunction
  function automatic string fmt(vec_t v);
    return $sformatf("pos=%0d dir=%0b tick=%0b acc=%0b idx=%0d click=%0b cacc=%0b",
                     v.pos, v.dir, v.tick, v.acc, v.idx, v.click, v.cacc);
  endfunction
  task automatic push(string tag, bit b, vec_t v);
    exp_t e;
    e.tag = tag;
    e.b = b;
    e.v = v;
    sb.push_back(e);
  endtask
  task automatic pop_check();
    exp_t e;
    vec_t o;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e = sb.pop_front();
    o = e.b ? ob : oa;
    assert (o === e.v) else begin
      fails++;
      $error("FAIL %s: got %s, want %s", e.tag, fmt(o), fmt(e.v));
    end
  endtask
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(bit b, int run, int spd, int bpb);
    if (b) begin
      ib.run = 1'(run);
      ib.speed = 3'(spd);
      ib.beats_per_bar = 3'(bpb);
    end else begin
      ia.run = 1'(run);
      ia.speed = 3'(spd);
      ia.beats_per_bar = 3'(bpb);
    end
  endtask
  task automatic idle(bit b);
    drive(b, 0, 1, 4);
    repeat (6) @(posedge clk);
    #1;
  endtask
  task automatic sweep(string tag, bit b, int n, int p, int tl, int bpb);
    drive(b, 1, 1, bpb);
    for (int k = 0; k <= n; k++) push($sformatf("%s k=%0d", tag, k), b, model(k, p, tl, bpb));
    for (int k = 0; k <= n; k++) begin
      edge1();
      pop_check();
    end
  endtask
  initial begin
    drive(0, 0, 1, 4);
    drive(1, 0, 1, 4);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push("reset_a", 0, mk(2, 1, 0, 0, 0, 0, 0));
    pop_check();
    push("reset_b", 1, mk(2, 1, 0, 0, 0, 0, 0));
    pop_check();
    rst = 1'b0;
    sweep("retrigger_b", 1, 20, 1, 6, 2);
    drive(1, 0, 1, 2);
    sweep("main", 0, 85, 4, 3, 4);
    drive(0, 0, 1, 4);
    push("run_drop", 0, mk(2, 1, 0, 0, 0, 0, 0));
    edge1();
    pop_check();
    sweep("restart", 0, 8, 4, 3, 4);
    drive(0, 0, 1, 4);
    push("drop_click0", 0, mk(2, 1, 0, 0, 0, 1, 1));
    push("drop_click1", 0, mk(2, 1, 0, 0, 0, 1, 1));
    push("drop_click2", 0, mk(2, 1, 0, 0, 0, 0, 0));
    repeat (3) begin
      edge1();
      pop_check();
    end
    idle(0);
    sweep("bpb0", 0, 75, 4, 3, 0);
    idle(0);
    sweep("bpb1", 0, 41, 4, 3, 1);
    idle(0);
    sweep("bpb7", 0, 88, 4, 3, 7);
    drive(0, 1, 1, 2);
    repeat (15) edge1();
    push("bpb_shrink", 0, mk(4, 0, 1, 1, 0, 1, 1));
    edge1();
    pop_check();
    idle(0);
    sweep("pre_pause", 0, 5, 4, 3, 4);
    drive(0, 1, 0, 4);
    for (int i = 0; i < 10; i++) push($sformatf("pause %0d", i), 0, mk(3, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      edge1();
      pop_check();
    end
    drive(0, 1, 1, 4);
    for (int i = 0; i < 3; i++) push($sformatf("resume %0d", i), 0, mk(3, 1, 0, 0, 0, 0, 0));
    push("resume_step", 0, mk(4, 0, 1, 1, 0, 1, 1));
    repeat (4) begin
      edge1();
      pop_check();
    end
    idle(0);
    drive(0, 1, 2, 4);
    for (int k = 0; k <= 5; k++) push($sformatf("slow k=%0d", k), 0, mk(2, 1, 0, 0, 0, 0, 0));
    for (int k = 0; k <= 5; k++) begin
      edge1();
      pop_check();
    end
    drive(0, 1, 4, 4);
    push("fast_step", 0, mk(3, 1, 0, 0, 0, 0, 0));
    push("fast_hold", 0, mk(3, 1, 0, 0, 0, 0, 0));
    push("fast_beat", 0, mk(4, 0, 1, 1, 0, 1, 1));
    repeat (3) begin
      edge1();
      pop_check();
    end
    idle(0);
    sweep("pre_rst", 0, 40, 4, 3, 4);
    #2 rst = 1'b1;
    #1;
    push("async_rst_a", 0, mk(2, 1, 0, 0, 0, 0, 0));
    pop_check();
    push("async_rst_b", 1, mk(2, 1, 0, 0, 0, 0, 0));
    pop_check();
    #3 rst = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
